regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 123 ++++++++++++
 tb/tb_regfile_sb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports and one writeback port, plus a
// per-register busy scoreboard that tracks destinations reserved by issuing instructions.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            write_enable,
    input  logic [AW-1:0]   rd_address,
    input  logic [XLEN-1:0] rd_data,
    input  logic [AW-1:0]   rs1_address,
    input  logic [AW-1:0]   rs2_address,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    output logic [AW:0]     pending_count
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      count_next;

    logic wr_is_zero;
    logic wr_commit;
    logic issue_commit;

    assign wr_is_zero   = ZERO_REG && (rd_address == '0);
    assign wr_commit    = reset_n && write_enable && !wr_is_zero;
    assign issue_commit = issue_valid && !(ZERO_REG && (issue_rd == '0));

    // NOTE: the storage array is cleared by reset because software-visible state must
    // read zero right after reset; without that requirement, leave memories unreset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[rd_address] <= rd_data;
        end
    end

    // Release first, then reserve, so a same-cycle reservation of the released register wins.
    always_comb begin
        // NOTE: every always_comb output gets a full default before any conditional
        // assignment; a missing default on some path would infer a latch.
        busy_next = busy;
        if (write_enable) begin
            busy_next[rd_address] = 1'b0;
        end
        if (issue_commit) begin
            busy_next[issue_rd] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_next[0] = 1'b0;
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_next = count_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples the values
    // from before the edge; = here would make results depend on statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy          <= '0;
            pending_count <= '0;
        end else begin
            busy          <= busy_next;
            pending_count <= count_next;
        end
    end

    // Read ports share one description; index 0 is rs1, index 1 is rs2.
    logic [AW-1:0]   rs_address [2];
    logic [XLEN-1:0] rs_value   [2];
    logic            rs_pending [2];

    assign rs_address[0] = rs1_address;
    assign rs_address[1] = rs2_address;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rs_value[p]   = regs[rs_address[p]];
            rs_pending[p] = busy[rs_address[p]]
                            && !(write_enable && (rd_address == rs_address[p]));
            if (BYPASS && wr_commit && (rd_address == rs_address[p])) begin
                rs_value[p] = rd_data;
            end
            if (ZERO_REG && (rs_address[p] == '0)) begin
                rs_value[p]   = '0;
                rs_pending[p] = 1'b0;
            end
        end
    end

    assign rs1_data = rs_value[0];
    assign rs2_data = rs_value[1];
    assign rs1_busy = rs_pending[0];
    assign rs2_busy = rs_pending[1];

    // WAW view of the issuing destination, masked by a same-cycle release.
    always_comb begin
        rd_busy = busy[issue_rd] && !(write_enable && (rd_address == issue_rd));
        if (ZERO_REG && (issue_rd == '0)) begin
            rd_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus;
// expected values are queued as stimulus is driven and popped when outputs are sampled.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            write_enable;
    logic [AW-1:0]   rd_address;
    logic [XLEN-1:0] rd_data;
    logic [AW-1:0]   rs1_address;
    logic [AW-1:0]   rs2_address;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;

    logic [XLEN-1:0] rs1_data, rs2_data, rs1_data_nb, rs2_data_nb;
    logic            rs1_busy, rs2_busy, rd_busy, rs1_busy_nb, rs2_busy_nb, rd_busy_nb;
    logic [AW:0]     pending_count, pending_count_nb;

    always #5 clock = ~clock;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
        .rd_address(rd_address), .rd_data(rd_data),
        .rs1_address(rs1_address), .rs2_address(rs2_address),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .pending_count(pending_count)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
        .rd_address(rd_address), .rd_data(rd_data),
        .rs1_address(rs1_address), .rs2_address(rs2_address),
        .rs1_data(rs1_data_nb), .rs2_data(rs2_data_nb),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_busy(rs1_busy_nb), .rs2_busy(rs2_busy_nb), .rd_busy(rd_busy_nb),
        .pending_count(pending_count_nb)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model used by the random phase.
    logic [31:0] m_regs [NREGS];
    bit          m_busy [NREGS];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] actual);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_underrun", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, actual, e.value);
        end
    endtask

    task automatic drive(input logic we, input int rd, input logic [31:0] data,
                         input int rs1, input int rs2, input logic iv, input int ird);
        write_enable = we;
        rd_address   = AW'(rd);
        rd_data      = data;
        rs1_address  = AW'(rs1);
        rs2_address  = AW'(rs2);
        issue_valid  = iv;
        issue_rd     = AW'(ird);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 32'h0, 0, 0, 1'b0, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] m_read(input int a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && write_enable && (int'(rd_address) == a)) return rd_data;
        return m_regs[a];
    endfunction

    function automatic logic m_busy_rd(input int a);
        if (a == 0) return 1'b0;
        return m_busy[a] && !(write_enable && (int'(rd_address) == a));
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state across every address.
        for (int a = 0; a < NREGS; a++) begin
            drive(1'b0, 0, 32'h0, a, NREGS - 1 - a, 1'b0, a);
            expect_val("reset_rs1_data", 32'h0);
            expect_val("reset_rs2_data", 32'h0);
            expect_val("reset_busy", 32'h0);
            compare(rs1_data);
            compare(rs2_data);
            compare({30'h0, rs1_busy, rs2_busy});
        end
        expect_val("reset_pending", 32'd0);
        compare(32'(pending_count));

        // Bypass vs. no-bypass on a write of x5.
        drive(1'b1, 5, 32'hDEADBEEF, 5, 5, 1'b0, 0);
        expect_val("bypass_same_cycle", 32'hDEADBEEF);
        expect_val("nobypass_old_value", 32'h0);
        compare(rs1_data);
        compare(rs1_data_nb);
        tick();
        drive(1'b0, 0, 32'h0, 5, 0, 1'b0, 0);
        expect_val("bypass_next_cycle", 32'hDEADBEEF);
        expect_val("nobypass_next_cycle", 32'hDEADBEEF);
        compare(rs1_data);
        compare(rs1_data_nb);

        // Zero register: write and reservation are both ignored.
        drive(1'b1, 0, 32'h12345678, 0, 0, 1'b1, 0);
        expect_val("x0_bypass_read", 32'h0);
        expect_val("x0_busy", 32'h0);
        expect_val("x0_rd_busy", 32'h0);
        compare(rs1_data);
        compare(32'(rs1_busy));
        compare(32'(rd_busy));
        tick();
        idle();
        expect_val("x0_read_after", 32'h0);
        expect_val("x0_pending", 32'd0);
        compare(rs1_data_nb);
        compare(32'(pending_count));

        // Reserve x3, then write and re-reserve x3 in the same cycle.
        drive(1'b0, 0, 32'h0, 3, 0, 1'b1, 3);
        tick();
        drive(1'b0, 0, 32'h0, 3, 0, 1'b0, 0);
        expect_val("x3_busy_c1", 32'd1);
        expect_val("x3_pending_c1", 32'd1);
        compare(32'(rs1_busy));
        compare(32'(pending_count));
        tick();
        drive(1'b1, 3, 32'h33, 3, 0, 1'b1, 3);
        expect_val("x3_busy_masked", 32'd0);
        expect_val("x3_rd_busy_masked", 32'd0);
        expect_val("x3_pending_c2", 32'd1);
        compare(32'(rs1_busy));
        compare(32'(rd_busy));
        compare(32'(pending_count));
        tick();
        drive(1'b0, 0, 32'h0, 3, 0, 1'b0, 0);
        expect_val("x3_busy_after", 32'd1);
        expect_val("x3_pending_after", 32'd1);
        expect_val("x3_data", 32'h33);
        compare(32'(rs1_busy));
        compare(32'(pending_count));
        compare(rs1_data);
        drive(1'b1, 3, 32'h33, 0, 0, 1'b0, 0);
        tick();
        idle();
        expect_val("x3_released", 32'd0);
        compare(32'(pending_count));

        // Reserve x1, x2, x4, then write back x2.
        drive(1'b0, 0, 32'h0, 0, 0, 1'b1, 1);
        tick();
        expect_val("pend_1", 32'd1);
        compare(32'(pending_count));
        drive(1'b0, 0, 32'h0, 0, 0, 1'b1, 2);
        tick();
        expect_val("pend_2", 32'd2);
        compare(32'(pending_count));
        drive(1'b0, 0, 32'h0, 0, 0, 1'b1, 4);
        tick();
        expect_val("pend_3", 32'd3);
        compare(32'(pending_count));
        drive(1'b1, 2, 32'h22, 1, 2, 1'b0, 0);
        expect_val("x2_rs2_masked", 32'd0);
        expect_val("x1_rs1_busy", 32'd1);
        compare(32'(rs2_busy));
        compare(32'(rs1_busy));
        tick();
        expect_val("pend_back_2", 32'd2);
        compare(32'(pending_count));

        // WAW: re-reserving a busy register is accepted and keeps it busy.
        drive(1'b0, 0, 32'h0, 0, 0, 1'b1, 4);
        expect_val("waw_rd_busy", 32'd1);
        compare(32'(rd_busy));
        tick();
        expect_val("waw_pending", 32'd2);
        compare(32'(pending_count));
        drive(1'b1, 1, 32'h11, 0, 0, 1'b0, 0);
        tick();
        drive(1'b1, 4, 32'h44, 0, 0, 1'b0, 0);
        tick();

        // Writeback to a non-busy register.
        drive(1'b1, 9, 32'h99, 0, 0, 1'b0, 0);
        tick();
        drive(1'b0, 0, 32'h0, 9, 2, 1'b0, 0);
        expect_val("x9_data", 32'h99);
        expect_val("x9_busy", 32'd0);
        expect_val("nonbusy_pending", 32'd0);
        expect_val("x2_data", 32'h22);
        compare(rs1_data);
        compare(32'(rs1_busy));
        compare(32'(pending_count));
        compare(rs2_data_nb);

        // Mid-operation reset with a write in the reset cycle.
        drive(1'b1, 10, 32'hA0, 0, 0, 1'b0, 0);
        tick();
        drive(1'b1, 11, 32'hB0, 0, 0, 1'b1, 7);
        tick();
        reset_n = 1'b0;
        drive(1'b1, 13, 32'hAAAA, 0, 0, 1'b1, 8);
        tick();
        reset_n = 1'b1;
        drive(1'b0, 0, 32'h0, 10, 13, 1'b0, 7);
        expect_val("rst_x10", 32'h0);
        expect_val("rst_x13_nb", 32'h0);
        expect_val("rst_pending", 32'd0);
        expect_val("rst_rd_busy_x7", 32'd0);
        compare(rs1_data);
        compare(rs2_data_nb);
        compare(32'(pending_count));
        compare(32'(rd_busy));
        drive(1'b0, 0, 32'h0, 7, 8, 1'b0, 0);
        expect_val("rst_busy_x7_x8", 32'd0);
        compare({30'h0, rs1_busy, rs2_busy});

        // Random phase against the reference model, starting from the reset state.
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)), $urandom(),
                  int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)));
            expect_val("rnd_rs1_data", m_read(int'(rs1_address), 1'b1));
            expect_val("rnd_rs2_data", m_read(int'(rs2_address), 1'b1));
            expect_val("rnd_rs1_data_nb", m_read(int'(rs1_address), 1'b0));
            expect_val("rnd_rs1_busy", 32'(m_busy_rd(int'(rs1_address))));
            expect_val("rnd_rs2_busy", 32'(m_busy_rd(int'(rs2_address))));
            expect_val("rnd_rd_busy", 32'(m_busy_rd(int'(issue_rd))));
            compare(rs1_data);
            compare(rs2_data);
            compare(rs1_data_nb);
            compare(32'(rs1_busy));
            compare(32'(rs2_busy));
            compare(32'(rd_busy));
            if (write_enable && rd_address != '0) m_regs[rd_address] = rd_data;
            if (write_enable) m_busy[rd_address] = 1'b0;
            if (issue_valid && issue_rd != '0) m_busy[issue_rd] = 1'b1;
            tick();
            expect_val("rnd_pending", 32'(m_count()));
            compare(32'(pending_count));
        end

        if (sb_q.size() != 0) check("scoreboard_leftover", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
